// File: rtl/fetch_queue_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel plus the
// decode-side queue head and redirect inputs.
interface fetch_queue_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            empty;
    logic            full;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, empty, full,
        input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, empty, full,
        output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch unit: owns the PC, keeps one imem request in flight and
// buffers returned words with their PCs in a DEPTH-entry FIFO for decode.
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             outstanding_q, outstanding_d;
    logic             drop_q, drop_d;
    logic [XLEN-1:0]  inst_mem_q [DEPTH];
    logic [XLEN-1:0]  inst_mem_d [DEPTH];
    logic [XLEN-1:0]  pc_mem_q   [DEPTH];
    logic [XLEN-1:0]  pc_mem_d   [DEPTH];

    logic req_c;
    logic accept_c;
    logic resp_c;
    logic write_c;
    logic consume_c;

    // Requests only go out when a slot is guaranteed free for the response.
    assign req_c     = !reset && !outstanding_q && !bus.redirect && (count_q < CNT_FULL);
    assign accept_c  = req_c && bus.imem_ready;
    assign resp_c    = bus.imem_rvalid && outstanding_q;
    assign write_c   = resp_c && !drop_q && !bus.redirect;
    assign consume_c = (count_q != '0) && bus.inst_ready && !bus.redirect;

    always_comb begin
        pc_d          = pc_q;
        fetch_pc_d    = fetch_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        inst_mem_d    = inst_mem_q;
        pc_mem_d      = pc_mem_q;

        if (resp_c) begin
            outstanding_d = 1'b0;
            drop_d        = 1'b0;
        end

        if (accept_c) begin
            pc_d          = pc_q + XLEN'(4);
            fetch_pc_d    = pc_q;
            outstanding_d = 1'b1;
        end

        if (write_c) begin
            inst_mem_d[wr_ptr_q] = bus.imem_rdata;
            pc_mem_d[wr_ptr_q]   = fetch_pc_q;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end

        if (consume_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(write_c) - CNT_W'(consume_c);

        // Redirect empties the queue; a still-pending response must be thrown away.
        if (bus.redirect) begin
            pc_d     = bus.redirect_pc & ~XLEN'(3);
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
            drop_d   = outstanding_q && !resp_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            fetch_pc_q    <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            inst_mem_q    <= '{default: '0};
            pc_mem_q      <= '{default: '0};
        end else begin
            pc_q          <= pc_d;
            fetch_pc_q    <= fetch_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            inst_mem_q    <= inst_mem_d;
            pc_mem_q      <= pc_mem_d;
        end
    end

    assign bus.imem_req   = req_c;
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = (count_q != '0);
    assign bus.inst       = inst_mem_q[rd_ptr_q];
    assign bus.inst_pc    = pc_mem_q[rd_ptr_q];
    assign bus.empty      = (count_q == '0);
    assign bus.full       = (count_q == CNT_FULL);
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle vector table plus a reset-mid-fetch
// sequence, with a small imem model returning word_of(addr) after a set latency.
module tb_fetch_queue;
    localparam int unsigned     XLEN     = 32;
    localparam int unsigned     DEPTH    = 4;
    localparam logic [XLEN-1:0] RESET_PC = '0;

    logic clk = 1'b0;
    logic reset;

    fetch_queue_if #(.XLEN(XLEN)) bus ();

    fetch_queue #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          sec;
        int          lat;
        bit          rst;
        bit          redir;
        logic [31:0] rpc;
        bit          irdy;
        bit          rdy;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_ipc;
        bit          e_empty;
        bit          e_full;
    } vec_t;

    vec_t        vecs[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          pend     = 1'b0;
    int          pwait    = 0;
    logic [31:0] paddr    = '0;
    int          lat      = 1;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic void add(input int sec, input int l, input bit redir, input logic [31:0] rpc,
                                input bit irdy, input bit rdy, input bit e_req, input logic [31:0] e_addr,
                                input bit e_valid, input logic [31:0] e_ipc, input bit e_full);
        vec_t v;
        v = '{sec: sec, lat: l, rst: 1'b0, redir: redir, rpc: rpc, irdy: irdy, rdy: rdy,
              e_req: e_req, e_addr: e_addr, e_valid: e_valid, e_ipc: e_ipc,
              e_empty: !e_valid, e_full: e_full};
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge; outputs settle by #1.
    task automatic drive(input vec_t v);
        @(negedge clk);
        reset            = v.rst;
        bus.redirect     = v.redir;
        bus.redirect_pc  = v.rpc;
        bus.inst_ready   = v.irdy;
        bus.imem_ready   = v.rdy;
        bus.imem_rvalid  = pend && (pwait == 0);
        bus.imem_rdata   = (pend && (pwait == 0)) ? word_of(paddr) : 32'h0;
        #1;
    endtask

    // Memory model: one outstanding read, answered lat cycles after acceptance.
    task automatic advance();
        bit acc;
        acc = bus.imem_req && bus.imem_ready;
        if (bus.imem_rvalid) pend = 1'b0;
        else if (pend) pwait--;
        if (acc) begin
            pend  = 1'b1;
            pwait = lat - 1;
            paddr = bus.imem_addr;
        end
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d imem_req", i),   32'(bus.imem_req),   32'(v.e_req));
        chk($sformatf("v%0d imem_addr", i),  bus.imem_addr,       v.e_addr);
        chk($sformatf("v%0d inst_valid", i), 32'(bus.inst_valid), 32'(v.e_valid));
        chk($sformatf("v%0d empty", i),      32'(bus.empty),      32'(v.e_empty));
        chk($sformatf("v%0d full", i),       32'(bus.full),       32'(v.e_full));
        if (v.e_valid) begin
            chk($sformatf("v%0d inst_pc", i), bus.inst_pc, v.e_ipc);
            chk($sformatf("v%0d inst", i),    bus.inst,    word_of(v.e_ipc));
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset           = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready  = 1'b0;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        pend            = 1'b0;
        pwait           = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t hv;
        int   prev_sec;

        // sec, lat, redir, rpc, irdy, rdy | req, addr, valid, inst_pc, full
        // Streaming: one instruction every two cycles.
        add(0, 1, 0, 0, 1, 1,  1, 32'h00, 0, 0, 0);
        add(0, 1, 0, 0, 1, 1,  0, 32'h04, 0, 0, 0);
        add(0, 1, 0, 0, 1, 1,  1, 32'h04, 1, 32'h00, 0);
        add(0, 1, 0, 0, 1, 1,  0, 32'h08, 0, 0, 0);
        add(0, 1, 0, 0, 1, 1,  1, 32'h08, 1, 32'h04, 0);
        add(0, 1, 0, 0, 1, 1,  0, 32'h0C, 0, 0, 0);
        add(0, 1, 0, 0, 1, 1,  1, 32'h0C, 1, 32'h08, 0);
        // Decode stalled: fill to DEPTH, then drain and refetch from 0x10.
        add(1, 1, 0, 0, 0, 1,  1, 32'h00, 0, 0, 0);
        add(1, 1, 0, 0, 0, 1,  0, 32'h04, 0, 0, 0);
        add(1, 1, 0, 0, 0, 1,  1, 32'h04, 1, 32'h00, 0);
        add(1, 1, 0, 0, 0, 1,  0, 32'h08, 1, 32'h00, 0);
        add(1, 1, 0, 0, 0, 1,  1, 32'h08, 1, 32'h00, 0);
        add(1, 1, 0, 0, 0, 1,  0, 32'h0C, 1, 32'h00, 0);
        add(1, 1, 0, 0, 0, 1,  1, 32'h0C, 1, 32'h00, 0);
        add(1, 1, 0, 0, 0, 1,  0, 32'h10, 1, 32'h00, 0);
        add(1, 1, 0, 0, 0, 1,  0, 32'h10, 1, 32'h00, 1);
        add(1, 1, 0, 0, 0, 1,  0, 32'h10, 1, 32'h00, 1);
        add(1, 1, 0, 0, 1, 1,  0, 32'h10, 1, 32'h00, 1);
        add(1, 1, 0, 0, 1, 1,  1, 32'h10, 1, 32'h04, 0);
        add(1, 1, 0, 0, 1, 1,  0, 32'h14, 1, 32'h08, 0);
        add(1, 1, 0, 0, 1, 1,  1, 32'h14, 1, 32'h0C, 0);
        add(1, 1, 0, 0, 1, 1,  0, 32'h18, 1, 32'h10, 0);
        add(1, 1, 0, 0, 1, 1,  1, 32'h18, 1, 32'h14, 0);
        // Redirect while fetch of 0x8 is in flight (latency 2); unaligned target.
        add(2, 2, 0, 0, 1, 1,  1, 32'h00, 0, 0, 0);
        add(2, 2, 0, 0, 1, 1,  0, 32'h04, 0, 0, 0);
        add(2, 2, 0, 0, 1, 1,  0, 32'h04, 0, 0, 0);
        add(2, 2, 0, 0, 1, 1,  1, 32'h04, 1, 32'h00, 0);
        add(2, 2, 0, 0, 1, 1,  0, 32'h08, 0, 0, 0);
        add(2, 2, 0, 0, 1, 1,  0, 32'h08, 0, 0, 0);
        add(2, 2, 0, 0, 1, 1,  1, 32'h08, 1, 32'h04, 0);
        add(2, 2, 1, 32'h103, 1, 1,  0, 32'h0C, 0, 0, 0);
        add(2, 2, 0, 0, 1, 1,  0, 32'h100, 0, 0, 0);
        add(2, 2, 0, 0, 1, 1,  1, 32'h100, 0, 0, 0);
        add(2, 2, 0, 0, 1, 1,  0, 32'h104, 0, 0, 0);
        add(2, 2, 0, 0, 1, 1,  0, 32'h104, 0, 0, 0);
        add(2, 2, 0, 0, 1, 1,  1, 32'h104, 1, 32'h100, 0);
        // Redirect in the same cycle as rvalid.
        add(3, 1, 0, 0, 1, 1,  1, 32'h00, 0, 0, 0);
        add(3, 1, 0, 0, 1, 1,  0, 32'h04, 0, 0, 0);
        add(3, 1, 0, 0, 1, 1,  1, 32'h04, 1, 32'h00, 0);
        add(3, 1, 1, 32'h200, 1, 1,  0, 32'h08, 0, 0, 0);
        add(3, 1, 0, 0, 1, 1,  1, 32'h200, 0, 0, 0);
        add(3, 1, 0, 0, 1, 1,  0, 32'h204, 0, 0, 0);
        add(3, 1, 0, 0, 1, 1,  1, 32'h204, 1, 32'h200, 0);
        // Redirect with a non-empty queue: flush, consume ignored, no request.
        add(4, 1, 0, 0, 0, 1,  1, 32'h00, 0, 0, 0);
        add(4, 1, 0, 0, 0, 1,  0, 32'h04, 0, 0, 0);
        add(4, 1, 0, 0, 0, 1,  1, 32'h04, 1, 32'h00, 0);
        add(4, 1, 0, 0, 0, 1,  0, 32'h08, 1, 32'h00, 0);
        add(4, 1, 1, 32'h40, 1, 1,  0, 32'h08, 1, 32'h00, 0);
        add(4, 1, 0, 0, 1, 1,  1, 32'h40, 0, 0, 0);
        add(4, 1, 0, 0, 1, 1,  0, 32'h44, 0, 0, 0);
        add(4, 1, 0, 0, 1, 1,  1, 32'h44, 1, 32'h40, 0);
        // Memory not ready for three cycles: request and address held.
        add(5, 1, 0, 0, 1, 0,  1, 32'h00, 0, 0, 0);
        add(5, 1, 0, 0, 1, 0,  1, 32'h00, 0, 0, 0);
        add(5, 1, 0, 0, 1, 0,  1, 32'h00, 0, 0, 0);
        add(5, 1, 0, 0, 1, 1,  1, 32'h00, 0, 0, 0);
        add(5, 1, 0, 0, 1, 1,  0, 32'h04, 0, 0, 0);
        add(5, 1, 0, 0, 1, 1,  1, 32'h04, 1, 32'h00, 0);
        // PC wraps past the top of the address space.
        add(6, 1, 1, 32'hFFFF_FFFF, 1, 1,  0, 32'h00, 0, 0, 0);
        add(6, 1, 0, 0, 1, 1,  1, 32'hFFFF_FFFC, 0, 0, 0);
        add(6, 1, 0, 0, 1, 1,  0, 32'h00, 0, 0, 0);
        add(6, 1, 0, 0, 1, 1,  1, 32'h00, 1, 32'hFFFF_FFFC, 0);

        // Reset values.
        reset           = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready  = 1'b0;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset imem_req",   32'(bus.imem_req),   32'h0);
        chk("reset imem_addr",  bus.imem_addr,       RESET_PC);
        chk("reset inst_valid", 32'(bus.inst_valid), 32'h0);
        chk("reset empty",      32'(bus.empty),      32'h1);
        chk("reset full",       32'(bus.full),       32'h0);
        chk("reset inst",       bus.inst,            32'h0);
        chk("reset inst_pc",    bus.inst_pc,         32'h0);

        prev_sec = -1;
        foreach (vecs[i]) begin
            if (vecs[i].sec != prev_sec) begin
                reset_dut();
                lat      = vecs[i].lat;
                prev_sec = vecs[i].sec;
            end
            drive(vecs[i]);
            check_vec(i, vecs[i]);
            advance();
        end

        // Reset asserted with a fetch in flight; its rvalid lands during reset.
        reset_dut();
        lat = 1;
        hv = '{sec: 9, lat: 1, rst: 1'b0, redir: 1'b0, rpc: 32'h0, irdy: 1'b1, rdy: 1'b1,
               e_req: 1'b1, e_addr: RESET_PC, e_valid: 1'b0, e_ipc: 32'h0,
               e_empty: 1'b1, e_full: 1'b0};
        drive(hv);
        check_vec(100, hv);
        advance();
        hv.rst = 1'b1;
        drive(hv);
        chk("midrst rvalid_driven", 32'(bus.imem_rvalid), 32'h1);
        chk("midrst imem_req",      32'(bus.imem_req),    32'h0);
        chk("midrst imem_addr",     bus.imem_addr,        RESET_PC);
        chk("midrst inst_valid",    32'(bus.inst_valid),  32'h0);
        chk("midrst empty",         32'(bus.empty),       32'h1);
        chk("midrst full",          32'(bus.full),        32'h0);
        chk("midrst inst",          bus.inst,             32'h0);
        chk("midrst inst_pc",       bus.inst_pc,          32'h0);
        advance();
        drive(hv);
        advance();
        hv.rst = 1'b0;
        drive(hv);
        check_vec(101, hv);
        advance();
        hv.e_req  = 1'b0;
        hv.e_addr = RESET_PC + 32'h4;
        drive(hv);
        check_vec(102, hv);
        advance();
        hv.e_req   = 1'b1;
        hv.e_valid = 1'b1;
        hv.e_ipc   = RESET_PC;
        hv.e_empty = 1'b0;
        drive(hv);
        check_vec(103, hv);
        advance();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
